bnn_sequencer: RTL and testbench
================================

// Module: bnn_sequencer
// PURPOSE
//  Top-level controller for the MNIST BNN inference datapath. Accepts a 28x28 binary
//  image as a byte stream, holds it in a pixel register, then steps the shared
//  state_t bus (s_IDLE/s_LOAD/s_LAYER_1/2/3) through the three layer engines. It
//  advances on each engine's done flag, latches the final class and guards each layer
//  with a watchdog. Sits between the chip I/O wrapper and the layer engines.
// PARAMETERS
//  IMG_DIM    28    image side; pixel register is IMG_DIM*IMG_DIM bits
//  BYTE_W     8     input stream width; IMG_DIM*IMG_DIM must be a multiple of BYTE_W
//  TIMEOUT    4095  max cycles allowed in any s_LAYER_* state before abort
//  CLASS_W    4     width of class index
// PORTS
//  clk           in   1          clock, all logic on posedge
//  rst           in   1          synchronous reset, active-high
//  start         in   1          request new inference; honoured only in s_IDLE
//  in_valid      in   1          input byte valid
//  in_data       in   BYTE_W     pixel byte, bit i = pixel (k*BYTE_W+i) of byte k
//  in_ready      out  1          high only in s_LOAD
//  state         out  3          state_t, registered, drives all layer engines
//  pixels        out  IMG_DIM^2  flattened image, pixel n at bit n (row-major)
//  l1_done       in   1          layer-1 done flag (level, sticky until engine reset)
//  l2_done       in   1          layer-2 done flag
//  l3_done       in   1          layer-3 done flag
//  l3_class      in   CLASS_W    classification from layer 3, valid with l3_done
//  layer_clr     out  1          1-cycle clear pulse to all layer engines
//  busy          out  1          state != s_IDLE
//  result_valid  out  1          level; class result available
//  result_class  out  CLASS_W    latched class
//  error         out  1          sticky watchdog abort flag
// BEHAVIOUR
//  Reset: state=s_IDLE, pixels=0, byte count=0, watchdog=0, in_ready=0, layer_clr=0,
//   result_valid=0, result_class=0, error=0. Reset mid-operation aborts immediately.
//  s_IDLE: start=1 -> s_LOAD next cycle; same cycle: byte count=0, result_valid=0,
//   error=0, layer_clr=1 for exactly that one cycle. in_data ignored in s_IDLE.
//  s_LOAD: in_ready=1. Byte accepted iff in_valid&in_ready; byte k written to
//   pixels[k*BYTE_W +: BYTE_W], count++. On acceptance of byte N-1 (N=IMG_DIM^2/BYTE_W,
//   98 by default) -> s_LAYER_1 next cycle, in_ready drops same edge. No timeout in
//   s_LOAD; gaps in in_valid are legal.
//  s_LAYER_1/2/3: watchdog cleared on state entry, +1 per cycle. lN_done sampled only
//   in its own state; other done flags ignored. l1_done=1 -> s_LAYER_2; l2_done=1 ->
//   s_LAYER_3; l3_done=1 -> s_IDLE with result_class<=l3_class, result_valid<=1.
//   Transition occurs at the edge where done is sampled high (1-cycle latency).
//  Watchdog: count reaching TIMEOUT without done -> s_IDLE, error<=1, layer_clr=1 for
//   one cycle, result_valid stays 0. done and timeout same cycle: done wins.
//  start while busy: ignored, no side effects. result_valid/result_class/error held
//   until next accepted start. pixels hold value through all layers and in s_IDLE.
//  state, in_ready, busy, layer_clr: all registered, no combinational in->out paths.
// TESTING
//  1. Reset, start, stream 98 bytes 0xA5 back-to-back -> in_ready high 98 cycles,
//     pixels = repeated 0xA5 pattern, state=s_LAYER_1 cycle after last byte.
//  2. Model l1/l2/l3_done each 200 cycles after state entry, l3_class=7 -> state
//     walks 2,3,4,0; result_valid=1, result_class=7; busy low in s_IDLE.
//  3. Random in_valid gaps (50% duty) while loading -> identical pixels to case 1;
//     start pulsed during LOAD/LAYER_2 -> no effect.
//  4. Hold l2_done=0 -> exactly TIMEOUT cycles in s_LAYER_2, then s_IDLE, error=1,
//     layer_clr 1-cycle pulse; next start clears error, layer_clr pulses again.
//  5. Assert rst during s_LAYER_3 and mid-LOAD (byte 40) -> next cycle all outputs
//     at reset values; fresh start reloads from byte 0.
//  6. l1_done already high entering s_LAYER_1 -> s_LAYER_2 after one cycle; l2_done
//     and timeout coincide -> s_LAYER_3, error stays 0.

Source files
------------

// File: rtl/bnn_sequencer.sv
// bnn_sequencer: top-level controller for the MNIST BNN inference datapath.
// Loads a binary image from a byte stream into a pixel register, then steps
// the shared state bus through the three layer engines, advancing on each
// engine's done flag. Every layer state is guarded by a watchdog.
//
// Handshake: a byte is transferred on a rising edge where in_valid and
// in_ready are both high. in_ready is registered and is high exactly while
// the state is s_LOAD. The source may hold in_valid low for any number of
// cycles, and in_data is ignored whenever no transfer takes place.
module bnn_sequencer #(
   parameter int IMG_DIM = 28,
   parameter int BYTE_W  = 8,
   parameter int TIMEOUT = 4095,
   parameter int CLASS_W = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       in_valid,
   input  logic [BYTE_W-1:0]          in_data,
   output logic                       in_ready,
   output logic [2:0]                 state,
   output logic [IMG_DIM*IMG_DIM-1:0] pixels,
   input  logic                       l1_done,
   input  logic                       l2_done,
   input  logic                       l3_done,
   input  logic [CLASS_W-1:0]         l3_class,
   output logic                       layer_clr,
   output logic                       busy,
   output logic                       result_valid,
   output logic [CLASS_W-1:0]         result_class,
   output logic                       error
);

   localparam int NPIX   = IMG_DIM * IMG_DIM;
   localparam int NBYTES = NPIX / BYTE_W;
   localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam int WD_W   = $clog2(TIMEOUT + 1);

   localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);
   // The watchdog holds the number of cycles already spent in the layer
   // state, so on the cycle where it reads TIMEOUT-1 the state has lasted
   // TIMEOUT cycles and must be abandoned at the next edge.
   localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_LAYER_1 = 3'd2,
      S_LAYER_2 = 3'd3,
      S_LAYER_3 = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [NPIX-1:0]     pix_q, pix_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [WD_W-1:0]     wd_q, wd_d;
   logic                in_ready_q, in_ready_d;
   logic                layer_clr_q, layer_clr_d;
   logic                busy_q, busy_d;
   logic                res_valid_q, res_valid_d;
   logic [CLASS_W-1:0]  res_class_q, res_class_d;
   logic                error_q, error_d;

   logic accept;
   logic timed_out;

   assign accept    = in_valid & in_ready_q;
   assign timed_out = (wd_q == WD_LAST);

   // Next-state, datapath and registered-output decode.
   always_comb begin
      state_d     = state_q;
      pix_d       = pix_q;
      cnt_d       = cnt_q;
      wd_d        = '0;
      res_valid_d = res_valid_q;
      res_class_d = res_class_q;
      error_d     = error_q;
      layer_clr_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d     = S_LOAD;
               cnt_d       = '0;
               res_valid_d = 1'b0;
               error_d     = 1'b0;
               layer_clr_d = 1'b1;
            end
         end
         S_LOAD: begin
            if (accept) begin
               pix_d[int'(cnt_q)*BYTE_W +: BYTE_W] = in_data;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_BYTE) begin
                  state_d = S_LAYER_1;
               end
            end
         end
         S_LAYER_1: begin
            wd_d = wd_q + WD_W'(1);
            if (l1_done) begin
               state_d = S_LAYER_2;
            end else if (timed_out) begin
               state_d     = S_IDLE;
               error_d     = 1'b1;
               layer_clr_d = 1'b1;
            end
         end
         S_LAYER_2: begin
            wd_d = wd_q + WD_W'(1);
            if (l2_done) begin
               state_d = S_LAYER_3;
            end else if (timed_out) begin
               state_d     = S_IDLE;
               error_d     = 1'b1;
               layer_clr_d = 1'b1;
            end
         end
         S_LAYER_3: begin
            wd_d = wd_q + WD_W'(1);
            if (l3_done) begin
               state_d     = S_IDLE;
               res_valid_d = 1'b1;
               res_class_d = l3_class;
            end else if (timed_out) begin
               state_d     = S_IDLE;
               error_d     = 1'b1;
               layer_clr_d = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Every state change restarts the watchdog from zero.
      if (state_d != state_q) begin
         wd_d = '0;
      end

      in_ready_d = (state_d == S_LOAD);
      busy_d     = (state_d != S_IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         pix_q       <= '0;
         cnt_q       <= '0;
         wd_q        <= '0;
         in_ready_q  <= 1'b0;
         layer_clr_q <= 1'b0;
         busy_q      <= 1'b0;
         res_valid_q <= 1'b0;
         res_class_q <= '0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         pix_q       <= pix_d;
         cnt_q       <= cnt_d;
         wd_q        <= wd_d;
         in_ready_q  <= in_ready_d;
         layer_clr_q <= layer_clr_d;
         busy_q      <= busy_d;
         res_valid_q <= res_valid_d;
         res_class_q <= res_class_d;
         error_q     <= error_d;
      end
   end

   assign state        = state_q;
   assign pixels       = pix_q;
   assign in_ready     = in_ready_q;
   assign layer_clr    = layer_clr_q;
   assign busy         = busy_q;
   assign result_valid = res_valid_q;
   assign result_class = res_class_q;
   assign error        = error_q;

endmodule

// File: tb/tb_bnn_sequencer.sv
// Testbench for bnn_sequencer: directed image loads and layer-engine models.
// State transitions and end-of-run result tuples are checked by a monitor
// against expected queues filled by the stimulus code.
module tb_bnn_sequencer;

   localparam int IMG_DIM = 28;
   localparam int BYTE_W  = 8;
   localparam int TIMEOUT = 4095;
   localparam int CLASS_W = 4;
   localparam int NPIX    = IMG_DIM * IMG_DIM;
   localparam int NBYTES  = NPIX / BYTE_W;

   localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_L1 = 3'd2, S_L2 = 3'd3, S_L3 = 3'd4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic               start = 1'b0;
   logic               in_valid = 1'b0;
   logic [BYTE_W-1:0]  in_data = '0;
   logic               in_ready;
   logic [2:0]         state;
   logic [NPIX-1:0]    pixels;
   logic               l1_done = 1'b0, l2_done = 1'b0, l3_done = 1'b0;
   logic [CLASS_W-1:0] l3_class = '0;
   logic               layer_clr, busy, result_valid, error;
   logic [CLASS_W-1:0] result_class;

   bnn_sequencer #(
      .IMG_DIM(IMG_DIM), .BYTE_W(BYTE_W), .TIMEOUT(TIMEOUT), .CLASS_W(CLASS_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .state(state), .pixels(pixels),
      .l1_done(l1_done), .l2_done(l2_done), .l3_done(l3_done), .l3_class(l3_class),
      .layer_clr(layer_clr), .busy(busy), .result_valid(result_valid),
      .result_class(result_class), .error(error)
   );

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   logic [2:0]       exp_state_q[$];
   logic [5:0]       exp_res_q[$];   // {error, result_valid, result_class}
   logic [NPIX-1:0]  exp_pix;
   logic [7:0]       img[NBYTES];
   logic [2:0]       prev_st = S_IDLE;
   bit               mon_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_pix(input string name);
      checks++;
      if (pixels !== exp_pix) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, pixels, exp_pix);
      end
   endtask

   // Monitor: every state change and every return to idle is matched
   // against the next expected entry.
   always @(negedge clk) begin
      if (mon_en && state !== prev_st) begin
         if (exp_state_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL state_seq: got unexpected transition %0d -> %0d at %0t", prev_st, state, $time);
         end else begin
            check("state_seq", state, exp_state_q.pop_front());
         end
         if (state == S_IDLE) begin
            if (exp_res_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL result_seq: got unexpected result event at %0t", $time);
            end else begin
               check("result_seq", {error, result_valid, result_class}, exp_res_q.pop_front());
            end
         end
      end
      prev_st = state;
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic set_img(input int kind);
      for (int k = 0; k < NBYTES; k++) begin
         case (kind)
            0:       img[k] = 8'hA5;
            1:       img[k] = 8'(k * 3 + 1);
            default: img[k] = ~8'(k);
         endcase
         exp_pix[k*BYTE_W +: BYTE_W] = img[k];
      end
   endtask

   task automatic push_states(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                              input logic [2:0] d, input logic [2:0] e, input int n);
      logic [2:0] s[5];
      s[0] = a; s[1] = b; s[2] = c; s[3] = d; s[4] = e;
      for (int i = 0; i < n; i++) exp_state_q.push_back(s[i]);
   endtask

   task automatic start_inf();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_state", state, S_LOAD);
      check("start_clr_pulse", layer_clr, 1);
      check("start_error_clr", error, 0);
      check("start_rv_clr", result_valid, 0);
      check("start_busy", busy, 1);
      tick();
      check("start_clr_one_cycle", layer_clr, 0);
   endtask

   // Streams img[0..nbytes-1]; start_at pulses start during that byte.
   task automatic load(input int nbytes, input bit gaps, input int start_at,
                       output int ready_cyc, output int iters);
      int  k = 0;
      bit  v, rdy;
      ready_cyc = 0;
      iters = 0;
      while (k < nbytes && iters < 2000) begin
         rdy = in_ready;
         if (rdy) ready_cyc++;
         v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         in_valid = v;
         in_data  = v ? img[k] : 8'($urandom_range(0, 255));
         start    = (k == start_at);
         tick();
         iters++;
         if (v && rdy) k++;
      end
      in_valid = 1'b0;
      start    = 1'b0;
      check("load_complete", k, nbytes);
   endtask

   task automatic wait_state(input logic [2:0] s, input string name);
      int g = 0;
      while (state !== s && g < 6000) begin
         tick();
         g++;
      end
      check(name, state, s);
   endtask

   task automatic set_done(input logic [2:0] s, input logic v);
      case (s)
         S_L1:    l1_done = v;
         S_L2:    l2_done = v;
         default: l3_done = v;
      endcase
   endtask

   // Models an engine finishing dly cycles after state entry.
   task automatic run_layer(input logic [2:0] s, input int dly, input logic [3:0] cls,
                            input bit pulse_start);
      wait_state(s, "layer_entry");
      for (int i = 0; i < dly; i++) begin
         start = pulse_start && (i == dly / 2);
         tick();
      end
      start = 1'b0;
      set_done(s, 1'b1);
      l3_class = cls;
      tick();
      check("layer_advance", state, (s == S_L3) ? S_IDLE : s + 3'd1);
   endtask

   task automatic clear_done();
      l1_done = 1'b0;
      l2_done = 1'b0;
      l3_done = 1'b0;
   endtask

   task automatic full_run(input int kind, input bit gaps, input int start_at,
                           input bit pulse_l2, input logic [3:0] cls);
      int rc, it;
      push_states(S_LOAD, S_L1, S_L2, S_L3, S_IDLE, 5);
      exp_res_q.push_back({1'b0, 1'b1, cls});
      set_img(kind);
      start_inf();
      load(NBYTES, gaps, start_at, rc, it);
      check("ready_every_cycle", rc, it);
      if (!gaps) check("ready_cycles_98", rc, NBYTES);
      check("load_to_l1", state, S_L1);
      check("ready_drop", in_ready, 0);
      check_pix("pixels_loaded");
      run_layer(S_L1, 200, cls, 1'b0);
      run_layer(S_L2, 200, cls, pulse_l2);
      run_layer(S_L3, 200, cls, 1'b0);
      check("result_valid", result_valid, 1);
      check("result_class", result_class, cls);
      check("busy_idle", busy, 0);
      check("error_clean", error, 0);
      check_pix("pixels_held");
      clear_done();
      tick();
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_state"}, state, S_IDLE);
      check({tag, "_ready"}, in_ready, 0);
      check({tag, "_clr"}, layer_clr, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_rv"}, result_valid, 0);
      check({tag, "_rc"}, result_class, 0);
      check({tag, "_err"}, error, 0);
      check({tag, "_pix_zero"}, 32'(|pixels), 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int cnt, rc, it;
      exp_pix = '0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check_reset_vals("reset");
      prev_st = state;
      mon_en  = 1'b1;

      // Cases 1 and 2: back-to-back load, layers finishing after 200 cycles.
      full_run(0, 1'b0, -1, 1'b0, 4'd7);

      // Case 3: gapped load plus stray start pulses during LOAD and LAYER_2.
      full_run(0, 1'b1, 50, 1'b1, 4'd9);

      // Case 4: layer 2 never finishes; watchdog aborts.
      push_states(S_LOAD, S_L1, S_L2, S_IDLE, S_IDLE, 4);
      exp_res_q.push_back({1'b1, 1'b0, 4'd9});
      set_img(1);
      start_inf();
      load(NBYTES, 1'b0, -1, rc, it);
      check_pix("pixels_ramp");
      run_layer(S_L1, 10, 4'd0, 1'b0);
      cnt = 0;
      while (state == S_L2 && cnt < TIMEOUT + 10) begin
         cnt++;
         tick();
      end
      check("timeout_cycles", cnt, TIMEOUT);
      check("timeout_state", state, S_IDLE);
      check("timeout_error", error, 1);
      check("timeout_clr", layer_clr, 1);
      check("timeout_rv", result_valid, 0);
      tick();
      check("timeout_clr_one_cycle", layer_clr, 0);
      clear_done();

      // Case 5a: reset in the middle of LOAD (after 40 bytes).
      push_states(S_LOAD, S_IDLE, S_IDLE, S_IDLE, S_IDLE, 2);
      exp_res_q.push_back(6'd0);
      start_inf();
      load(40, 1'b0, -1, rc, it);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_reset_vals("rst_load");

      // Case 5b: fresh image loads from byte 0, then reset during LAYER_3.
      push_states(S_LOAD, S_L1, S_L2, S_L3, S_IDLE, 5);
      exp_res_q.push_back(6'd0);
      set_img(2);
      start_inf();
      load(NBYTES, 1'b0, -1, rc, it);
      check_pix("pixels_reload");
      run_layer(S_L1, 5, 4'd0, 1'b0);
      run_layer(S_L2, 5, 4'd0, 1'b0);
      wait_state(S_L3, "l3_entry");
      repeat (20) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_reset_vals("rst_l3");
      clear_done();

      // Case 6: l1_done already high; l2_done coincides with the timeout.
      push_states(S_LOAD, S_L1, S_L2, S_L3, S_IDLE, 5);
      exp_res_q.push_back({1'b0, 1'b1, 4'd5});
      set_img(0);
      start_inf();
      l1_done = 1'b1;
      load(NBYTES, 1'b0, -1, rc, it);
      check("pre_done_l1", state, S_L1);
      tick();
      check("pre_done_l2", state, S_L2);
      repeat (TIMEOUT - 1) tick();
      check("still_l2", state, S_L2);
      l2_done = 1'b1;
      tick();
      check("done_beats_timeout", state, S_L3);
      check("done_beats_timeout_err", error, 0);
      run_layer(S_L3, 3, 4'd5, 1'b0);
      check("final_rv", result_valid, 1);
      check("final_rc", result_class, 5);
      clear_done();

      repeat (3) tick();
      check("state_queue_empty", exp_state_q.size(), 0);
      check("result_queue_empty", exp_res_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global time bound so the run always ends.
   initial begin
      #600000;
      $display("FAIL global_timeout: got no end expected end by 600000");
      $fatal(1, "global timeout");
   end

endmodule
